// File: rtl/age_reservation_station.sv
// Age-ordered reservation station: multi-lane enqueue, CDB wakeup with enqueue bypass,
// and per-class oldest-first selection relative to the ROB head.
// Entry payload layout, MSB first: {ps1_addr, ps1_valid, ps2_addr, ps2_valid, rob_idx}.
module age_reservation_station #(
  parameter int unsigned PR_BITS   = 6,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ENQ_WIDTH = 2,
  parameter int unsigned CDB_COUNT = 2,
  parameter int unsigned NCLASS    = 4,
  parameter int unsigned ROB_BITS  = 5,
  localparam int unsigned ENTRY_W  = 2 * PR_BITS + 2 + ROB_BITS,
  localparam int unsigned CLS_W    = (NCLASS > 1) ? $clog2(NCLASS) : 1,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [ENQ_WIDTH-1:0]                enq_valid,
  input  logic [ENQ_WIDTH-1:0][ENTRY_W-1:0]   enq_entry,
  input  logic [ENQ_WIDTH-1:0][CLS_W-1:0]     enq_class,
  output logic                                enq_ready,
  output logic [CNT_W-1:0]                    free_count,
  input  logic [CDB_COUNT-1:0]                cdb_valid,
  input  logic [CDB_COUNT-1:0][PR_BITS-1:0]   cdb_pr,
  input  logic [ROB_BITS-1:0]                 rob_head,
  output logic [NCLASS-1:0]                   iss_valid,
  output logic [NCLASS-1:0][ENTRY_W-1:0]      iss_entry,
  input  logic [NCLASS-1:0]                   iss_ready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PR_BITS-1:0]  ps1_addr;
    logic                ps1_valid;
    logic [PR_BITS-1:0]  ps2_addr;
    logic                ps2_valid;
    logic [ROB_BITS-1:0] rob_idx;
  } rs_entry_t;

  logic [DEPTH-1:0]                  inuse_q, inuse_d;
  rs_entry_t [DEPTH-1:0]             ent_q, ent_d;
  logic [DEPTH-1:0][CLS_W-1:0]       cls_q, cls_d;

  logic [CNT_W-1:0]                  used;
  logic [DEPTH-1:0]                  ready;
  logic [DEPTH-1:0][ROB_BITS-1:0]    age;
  logic [NCLASS-1:0]                 sel_found;
  logic [NCLASS-1:0][IDX_W-1:0]      sel_idx;
  logic [NCLASS-1:0][ROB_BITS-1:0]   best_age;
  logic [DEPTH-1:0]                  deq;

  logic                              do_enq;
  logic [DEPTH-1:0]                  taken;
  logic [ENQ_WIDTH-1:0]              lane_ok;
  logic [ENQ_WIDTH-1:0][IDX_W-1:0]   lane_slot;
  rs_entry_t [ENQ_WIDTH-1:0]         enq_byp;

  // Occupancy from registered inuse only, so enq_ready never depends on same-cycle issue.
  always_comb begin
    used = '0;
    for (int i = 0; i < DEPTH; i++) begin
      used = used + CNT_W'(inuse_q[i]);
    end
    free_count = CNT_W'(DEPTH) - used;
    enq_ready  = (free_count >= CNT_W'(ENQ_WIDTH));
  end

  // Readiness and age (distance from ROB head, modulo the index width) of every entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = inuse_q[i] & ent_q[i].ps1_valid & ent_q[i].ps2_valid;
      age[i]   = ent_q[i].rob_idx - rob_head;
    end
  end

  // Oldest-ready selection per class, issue outputs and dequeue mask.
  always_comb begin
    sel_found = '0;
    sel_idx   = '0;
    best_age  = '0;
    deq       = '0;
    for (int c = 0; c < NCLASS; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ready[i] && (cls_q[i] == CLS_W'(c)) && (!sel_found[c] || (age[i] < best_age[c]))) begin
          sel_found[c] = 1'b1;
          sel_idx[c]   = IDX_W'(i);
          best_age[c]  = age[i];
        end
      end
    end
    for (int c = 0; c < NCLASS; c++) begin
      iss_valid[c] = sel_found[c] & ~flush;
      iss_entry[c] = ent_q[sel_idx[c]];
      for (int i = 0; i < DEPTH; i++) begin
        if (iss_valid[c] && iss_ready[c] && (sel_idx[c] == IDX_W'(i))) begin
          deq[i] = 1'b1;
        end
      end
    end
  end

  // Slot allocation: lanes in ascending order take the lowest slots free at the last edge.
  always_comb begin
    do_enq    = enq_ready & ~flush;
    taken     = inuse_q;
    lane_ok   = '0;
    lane_slot = '0;
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      if (do_enq && enq_valid[l]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!taken[i] && !lane_ok[l]) begin
            lane_ok[l]   = 1'b1;
            lane_slot[l] = IDX_W'(i);
            taken[i]     = 1'b1;
          end
        end
      end
    end
  end

  // Enqueue bypass: a source produced on the CDB this cycle is captured as already valid.
  always_comb begin
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      enq_byp[l] = rs_entry_t'(enq_entry[l]);
      for (int j = 0; j < CDB_COUNT; j++) begin
        if (cdb_valid[j] && (enq_byp[l].ps1_addr == cdb_pr[j])) enq_byp[l].ps1_valid = 1'b1;
        if (cdb_valid[j] && (enq_byp[l].ps2_addr == cdb_pr[j])) enq_byp[l].ps2_valid = 1'b1;
      end
    end
  end

  // Next state: dequeue, wakeup of resident entries, then writes of newly allocated slots.
  always_comb begin
    ent_d   = ent_q;
    cls_d   = cls_q;
    inuse_d = inuse_q & ~deq;
    if (flush) begin
      inuse_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < CDB_COUNT; j++) begin
          if (inuse_q[i] && cdb_valid[j]) begin
            if (ent_q[i].ps1_addr == cdb_pr[j]) ent_d[i].ps1_valid = 1'b1;
            if (ent_q[i].ps2_addr == cdb_pr[j]) ent_d[i].ps2_valid = 1'b1;
          end
        end
      end
      for (int l = 0; l < ENQ_WIDTH; l++) begin
        if (lane_ok[l]) begin
          ent_d[lane_slot[l]]   = enq_byp[l];
          cls_d[lane_slot[l]]   = enq_class[l];
          inuse_d[lane_slot[l]] = 1'b1;
        end
      end
    end
  end

  // Occupancy register; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) inuse_q <= '0;
    else     inuse_q <= inuse_d;
  end

  // Payload registers are deliberately left unreset; inuse qualifies them.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    cls_q <= cls_d;
  end

endmodule

// File: tb/tb_age_reservation_station.sv
// Bench for age_reservation_station: directed scenarios followed by random traffic,
// all checked against an unordered-collection model of the station contents.
module tb_age_reservation_station;

  localparam int DEPTH  = 8;
  localparam int ENQ_W  = 2;
  localparam int NCLASS = 4;

  typedef struct {
    int rob;
    int ps1;
    bit v1;
    int ps2;
    bit v2;
    int cls;
  } m_ent_t;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [1:0]       enq_valid;
  logic [1:0][18:0] enq_entry;
  logic [1:0][1:0]  enq_class;
  logic             enq_ready;
  logic [3:0]       free_count;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_pr;
  logic [4:0]       rob_head;
  logic [3:0]       iss_valid;
  logic [3:0][18:0] iss_entry;
  logic [3:0]       iss_ready;

  age_reservation_station #(
    .PR_BITS(6), .DEPTH(8), .ENQ_WIDTH(2), .CDB_COUNT(2), .NCLASS(4), .ROB_BITS(5)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_entry(enq_entry), .enq_class(enq_class),
    .enq_ready(enq_ready), .free_count(free_count),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr), .rob_head(rob_head),
    .iss_valid(iss_valid), .iss_entry(iss_entry), .iss_ready(iss_ready)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  m_ent_t   model[$];
  bit       b_rst, b_flush;
  bit       lv[2];
  m_ent_t   lane[2];
  bit       cv[2];
  int       cp[2];
  int       head;
  bit [3:0] rdy;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] pack(m_ent_t e);
    return {6'(e.ps1), e.v1, 6'(e.ps2), e.v2, 5'(e.rob)};
  endfunction

  // Oldest ready entry of a class, by distance from the ROB head; -1 if none.
  function automatic int select(int c);
    int best = -1;
    int best_age = 0;
    foreach (model[k]) begin
      if (model[k].cls == c && model[k].v1 && model[k].v2) begin
        int a = (model[k].rob - head + 32) % 32;
        if (best < 0 || a < best_age) begin
          best = k;
          best_age = a;
        end
      end
    end
    return best;
  endfunction

  function automatic m_ent_t wake(m_ent_t e);
    m_ent_t r = e;
    for (int j = 0; j < 2; j++) begin
      if (cv[j] && cp[j] == r.ps1) r.v1 = 1'b1;
      if (cv[j] && cp[j] == r.ps2) r.v2 = 1'b1;
    end
    return r;
  endfunction

  function automatic int pick_rob(int other);
    int r;
    bit clash;
    do begin
      r = $urandom_range(0, 31);
      clash = (r == other);
      foreach (model[k]) if (model[k].rob == r) clash = 1'b1;
    end while (clash);
    return r;
  endfunction

  task automatic clr();
    b_rst = 0; b_flush = 0; rdy = 4'b0000;
    for (int l = 0; l < 2; l++) lv[l] = 0;
    for (int j = 0; j < 2; j++) begin cv[j] = 0; cp[j] = 0; end
  endtask

  task automatic set_lane(int l, int rob, int ps1, bit v1, int ps2, bit v2, int cls);
    lv[l] = 1'b1;
    lane[l].rob = rob; lane[l].ps1 = ps1; lane[l].v1 = v1;
    lane[l].ps2 = ps2; lane[l].v2 = v2; lane[l].cls = cls;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model, cross the edge.
  task automatic step();
    int       sel[NCLASS];
    int       exp_free;
    bit       exp_rdy;
    bit [3:0] exp_iv;
    bit       keep;
    m_ent_t   nm[$];
    rst = b_rst; flush = b_flush; rob_head = 5'(head); iss_ready = rdy;
    for (int l = 0; l < 2; l++) begin
      enq_valid[l] = lv[l];
      enq_entry[l] = pack(lane[l]);
      enq_class[l] = 2'(lane[l].cls);
    end
    for (int j = 0; j < 2; j++) begin
      cdb_valid[j] = cv[j];
      cdb_pr[j]    = 6'(cp[j]);
    end
    #1;
    exp_free = DEPTH - model.size();
    exp_rdy  = (exp_free >= ENQ_W);
    check("free_count", 32'(free_count), 32'(exp_free));
    check("enq_ready", 32'(enq_ready), 32'(exp_rdy));
    for (int c = 0; c < NCLASS; c++) begin
      sel[c] = select(c);
      exp_iv[c] = !b_flush && (sel[c] >= 0);
    end
    check("iss_valid", 32'(iss_valid), 32'(exp_iv));
    for (int c = 0; c < NCLASS; c++) begin
      if (exp_iv[c]) check($sformatf("iss_entry[%0d]", c), 32'(iss_entry[c]), 32'(pack(model[sel[c]])));
    end
    if (!(b_rst || b_flush)) begin
      foreach (model[k]) begin
        keep = 1'b1;
        for (int c = 0; c < NCLASS; c++) if (exp_iv[c] && rdy[c] && sel[c] == k) keep = 1'b0;
        if (keep) nm.push_back(wake(model[k]));
      end
      if (exp_rdy) begin
        for (int l = 0; l < 2; l++) if (lv[l]) nm.push_back(wake(lane[l]));
      end
    end
    model = nm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    head = 0;
    rst = 1; flush = 0; enq_valid = '0; enq_entry = '0; enq_class = '0;
    cdb_valid = '0; cdb_pr = '0; rob_head = '0; iss_ready = '0;
    repeat (2) @(posedge clk);
    #1;

    // Two ready class-0 entries; oldest first, then the other, then empty.
    clr();
    set_lane(0, 3, 1, 1, 2, 1, 0);
    set_lane(1, 4, 3, 1, 4, 1, 0);
    step();
    check("t1 valid0", 32'(iss_valid[0]), 32'd1);
    check("t1 rob3", 32'(iss_entry[0][4:0]), 32'd3);
    clr(); rdy = 4'b0001;
    step();
    check("t1 rob4", 32'(iss_entry[0][4:0]), 32'd4);
    step();
    check("t1 free8", 32'(free_count), 32'd8);

    // Age wraps past the ROB index boundary.
    clr(); head = 30;
    set_lane(0, 1, 5, 1, 6, 1, 1);
    set_lane(1, 31, 7, 1, 8, 1, 1);
    step();
    check("t2 rob31", 32'(iss_entry[1][4:0]), 32'd31);
    clr(); rdy = 4'b0010;
    step();
    check("t2 rob1", 32'(iss_entry[1][4:0]), 32'd1);
    step();

    // Same-cycle CDB bypass on enqueue.
    clr(); head = 0;
    set_lane(0, 7, 9, 0, 5, 1, 2);
    cv[1] = 1; cp[1] = 9;
    step();
    check("t3 bypass", 32'(iss_valid[2]), 32'd1);
    clr(); rdy = 4'b0100;
    step();

    // Fill to seven, attempt an ignored enqueue, drain two.
    clr();
    set_lane(0, 10, 1, 1, 1, 1, 0);
    set_lane(1, 11, 1, 1, 1, 1, 0);
    step();
    set_lane(0, 12, 2, 1, 2, 1, 1);
    set_lane(1, 13, 40, 0, 2, 1, 3);
    step();
    set_lane(0, 14, 40, 0, 2, 1, 3);
    set_lane(1, 15, 40, 0, 2, 1, 3);
    step();
    clr();
    set_lane(0, 16, 40, 0, 2, 1, 3);
    step();
    check("t4 enq_ready0", 32'(enq_ready), 32'd0);
    set_lane(0, 17, 1, 1, 1, 1, 0);
    set_lane(1, 18, 1, 1, 1, 1, 0);
    step();
    check("t4 free1", 32'(free_count), 32'd1);
    clr(); rdy = 4'b0001;
    step();
    check("t4 enq_ready1", 32'(enq_ready), 32'd1);
    step();

    // Flush with five entries (one ready) and an enqueue pending.
    clr();
    set_lane(0, 20, 1, 1, 1, 1, 0);
    b_flush = 1; rdy = 4'b1111;
    step();
    check("t5 free8", 32'(free_count), 32'd8);

    // Reset mid-stream with CDB and enqueue active.
    clr();
    set_lane(0, 21, 3, 1, 3, 1, 2);
    set_lane(1, 22, 4, 0, 3, 1, 2);
    step();
    set_lane(0, 23, 4, 1, 4, 1, 0);
    set_lane(1, 24, 5, 0, 5, 0, 1);
    cv[0] = 1; cp[0] = 4; cv[1] = 1; cp[1] = 5;
    b_rst = 1;
    step();
    check("t6 free8", 32'(free_count), 32'd8);
    check("t6 iss0", 32'(iss_valid), 32'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      clr();
      for (int j = 0; j < 2; j++) begin
        cv[j] = ($urandom_range(0, 1) == 1);
        cp[j] = $urandom_range(0, 15);
      end
      for (int l = 0; l < 2; l++) begin
        set_lane(l, pick_rob(l == 1 ? lane[0].rob : -1),
                 $urandom_range(0, 15), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 15), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 3));
        lv[l] = ($urandom_range(0, 9) < 6);
      end
      rdy     = 4'($urandom_range(0, 15));
      b_flush = ($urandom_range(0, 99) < 3);
      b_rst   = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 15) == 0) head = $urandom_range(0, 31);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
